sobel_stream: RTL and testbench

- Streaming 3x3 Sobel edge stage directly downstream of the grayscale averaging stage.
- Consumes one 8-bit gray pixel per accepted beat, in raster order, for an IMG_W x IMG_H frame (default 32x32, i.e. a 3072-byte RGB input reduced to 1024 gray pixels).
- Emits one 8-bit gradient magnitude per pixel in raster order, plus a frame-done pulse.
- Uses two internal line buffers and a 3x3 window register array. Flushes the tail of the frame on its own once the last input pixel has been accepted.

---
 rtl/sobel_stream.sv | 178 +++++++++++++++++
 tb/tb_sobel_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel gradient magnitude stage
//
// Accepts one 8-bit gray pixel per handshake in raster order and emits one
// saturated |Gx|+|Gy| magnitude per pixel, also in raster order. After the
// last pixel of a frame is accepted, the remaining border outputs are
// flushed without further input.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset         synchronous active-high reset
//   gray_in       gray pixel
//   gray_valid_i  gray_in valid
//   gray_ready_o  stage can accept a pixel (low while flushing)
//   sobel_out     saturated gradient magnitude
//   sobel_valid_o sobel_out valid, no backpressure
//   sobel_done_o  pulse with the last output of a frame
module sobel_stream #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic [7:0] gray_in,
    input  logic       gray_valid_i,
    output logic       gray_ready_o,
    output logic [7:0] sobel_out,
    output logic       sobel_valid_o,
    output logic       sobel_done_o
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int IW   = $clog2(NPIX);
    localparam int FW   = $clog2(IMG_W + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [IW-1:0] IDX_FIRST  = IW'(IMG_W + 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NPIX - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] in_col;
    logic [IW-1:0] in_idx;
    logic [CW-1:0] c_col;
    logic [RW-1:0] c_row;
    logic [FW-1:0] flush_cnt;

    logic [7:0] line_buf0 [IMG_W];
    logic [7:0] line_buf1 [IMG_W];
    logic [7:0] win  [3][3];
    logic [7:0] nwin [3][3];

    logic accept;
    logic produce;
    logic border;

    logic [9:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx, gy;
    logic [10:0]       ax, ay;
    logic [11:0]       mag;
    logic [7:0]        sat;

    assign gray_ready_o = (state != S_FLUSH);
    assign accept       = gray_valid_i && gray_ready_o;
    // The accept of pixel k+IMG_W+1 completes the window centred on pixel k.
    assign produce      = accept && (in_idx >= IDX_FIRST);

    // Window as it will look after this accept: shift left, new right column
    // comes from the two line buffers plus the incoming pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nwin[r][0] = win[r][1];
            nwin[r][1] = win[r][2];
        end
        nwin[0][2] = line_buf1[in_col];
        nwin[1][2] = line_buf0[in_col];
        nwin[2][2] = gray_in;
    end

    always_comb begin
        gx_pos = {2'b00, nwin[0][2]} + {1'b0, nwin[1][2], 1'b0} + {2'b00, nwin[2][2]};
        gx_neg = {2'b00, nwin[0][0]} + {1'b0, nwin[1][0], 1'b0} + {2'b00, nwin[2][0]};
        gy_pos = {2'b00, nwin[2][0]} + {1'b0, nwin[2][1], 1'b0} + {2'b00, nwin[2][2]};
        gy_neg = {2'b00, nwin[0][0]} + {1'b0, nwin[0][1], 1'b0} + {2'b00, nwin[0][2]};
        gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
        ax     = gx[10] ? 11'(-gx) : 11'(gx);
        ay     = gy[10] ? 11'(-gy) : 11'(gy);
        mag    = {1'b0, ax} + {1'b0, ay};
        sat    = (mag > 12'd255) ? 8'hFF : mag[7:0];
    end

    // Border centres are forced to zero; this also hides the window columns
    // that straddle a row wrap.
    assign border = (c_row == '0) || (c_row == ROW_LAST) ||
                    (c_col == '0) || (c_col == COL_LAST);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state         <= S_IDLE;
            in_col        <= '0;
            in_idx        <= '0;
            c_col         <= '0;
            c_row         <= '0;
            flush_cnt     <= '0;
            sobel_out     <= 8'h00;
            sobel_valid_o <= 1'b0;
            sobel_done_o  <= 1'b0;
        end else begin
            sobel_valid_o <= 1'b0;
            sobel_done_o  <= 1'b0;

            if (accept) begin
                in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
                in_idx <= (in_idx == IDX_LAST) ? '0 : in_idx + 1'b1;
                case (state)
                    S_IDLE: state <= S_FILL;
                    S_FILL: if (in_idx == IDX_FIRST) state <= S_RUN;
                    S_RUN: begin
                        if (in_idx == IDX_LAST) begin
                            state     <= S_FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                    default: state <= state;
                endcase
            end

            if (produce) begin
                sobel_valid_o <= 1'b1;
                sobel_out     <= border ? 8'h00 : sat;
                if (c_col == COL_LAST) begin
                    c_col <= '0;
                    c_row <= c_row + 1'b1;
                end else begin
                    c_col <= c_col + 1'b1;
                end
            end

            // Tail of the frame: last row plus the end of the row above it,
            // all border pixels, one per cycle.
            if (state == S_FLUSH) begin
                sobel_valid_o <= 1'b1;
                sobel_out     <= 8'h00;
                if (flush_cnt == FLUSH_LAST) begin
                    sobel_done_o <= 1'b1;
                    state        <= S_IDLE;
                    flush_cnt    <= '0;
                    c_col        <= '0;
                    c_row        <= '0;
                end else begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end
        end
    end

    // Pixel storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= nwin[r][c];
                end
            end
            line_buf1[in_col] <= line_buf0[in_col];
            line_buf0[in_col] <= gray_in;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - directed testbench for sobel_stream
module tb_sobel_stream;

    localparam int W = 32;
    localparam int H = 32;
    localparam int N = W * H;

    localparam int P_CONST = 0;
    localparam int P_VSTEP = 1;
    localparam int P_RAMP  = 2;
    localparam int P_IMP   = 3;

    logic       clk_i = 1'b0;
    logic       reset;
    logic [7:0] gray_in;
    logic       gray_valid_i;
    logic       gray_ready_o;
    logic [7:0] sobel_out;
    logic       sobel_valid_o;
    logic       sobel_done_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] outs[$];
    int         oedge[$];
    int         done_idx[$];
    int         rlow = 0;

    int acc_edges[$];
    bit acc_mark[int];
    int last_acc_edge = 0;

    sobel_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .gray_in      (gray_in),
        .gray_valid_i (gray_valid_i),
        .gray_ready_o (gray_ready_o),
        .sobel_out    (sobel_out),
        .sobel_valid_o(sobel_valid_o),
        .sobel_done_o (sobel_done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (sobel_valid_o === 1'b1) begin
            if (sobel_done_o === 1'b1) done_idx.push_back(outs.size());
            outs.push_back(sobel_out);
            oedge.push_back(cyc);
        end else if (sobel_done_o === 1'b1) begin
            done_idx.push_back(-1);
        end
        if (gray_ready_o === 1'b0) rlow <= rlow + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        case (pat)
            P_CONST: return 8'h80;
            P_VSTEP: return (c >= 16) ? 8'hFF : 8'h00;
            P_RAMP:  return 8'(c);
            P_IMP:   return (r == 5 && c == 5) ? 8'h10 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_px(input int pat, input int r, input int c);
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
        case (pat)
            P_VSTEP: return (c == 15 || c == 16) ? 8'hFF : 8'h00;
            P_RAMP:  return 8'h08;
            P_IMP:   return (r >= 4 && r <= 6 && c >= 4 && c <= 6 && !(r == 5 && c == 5)) ? 8'h20 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int count_bad(input int pat, input int base);
        int bad = 0;
        for (int k = 0; k < N; k++) begin
            if (outs.size() <= base + k) bad++;
            else if (outs[base + k] !== exp_px(pat, k / W, k % W)) bad++;
        end
        return bad;
    endfunction

    task automatic drive(input int pat_a, input int pat_b, input int npix, input int gap_pct);
        int  i = 0;
        int  budget = 0;
        int  f, p;
        bit  v;
        while (i < npix && budget < 20000) begin
            @(negedge clk_i);
            budget++;
            v = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
            f = i / N;
            p = i % N;
            gray_valid_i = v;
            gray_in      = pix((f == 0) ? pat_a : pat_b, p / W, p % W);
            if (v && gray_ready_o === 1'b1) begin
                acc_edges.push_back(cyc + 1);
                acc_mark[cyc + 1] = 1'b1;
                last_acc_edge = cyc + 1;
                i++;
            end
        end
        checks++;
        if (i != npix) begin
            errors++;
            $display("FAIL drive_accepts: accepted %0d expected %0d", i, npix);
        end
        @(negedge clk_i);
        gray_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int want);
        int t = 0;
        while (done_idx.size() < want && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        checks++;
        if (done_idx.size() < want) begin
            errors++;
            $display("FAIL done_timeout: got %0d done pulses expected %0d", done_idx.size(), want);
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        gray_valid_i = 1'b0;
        gray_in = 8'h00;
        repeat (3) @(negedge clk_i);
        checks++; if (sobel_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sobel_valid_o); end
        checks++; if (sobel_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", sobel_done_o); end
        checks++; if (sobel_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", sobel_out); end
        checks++; if (gray_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", gray_ready_o); end
        reset = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_constant();
        int base, d0, r0, a0, bad, fv, av;
        base = outs.size(); d0 = done_idx.size(); r0 = rlow; a0 = acc_edges.size();
        drive(P_CONST, P_CONST, N, 0);
        wait_done(d0 + 1);
        bad = count_bad(P_CONST, base);
        fv = (outs.size() > base) ? oedge[base] : -1;
        av = (acc_edges.size() > a0 + 33) ? acc_edges[a0 + 33] : -2;
        checks++; if (outs.size() - base !== N) begin errors++; $display("FAIL const_count: got %0d expected %0d", outs.size() - base, N); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL const_data: %0d wrong outputs expected 0", bad); end
        checks++; if (fv !== av) begin errors++; $display("FAIL const_first_valid: edge %0d expected %0d", fv, av); end
        checks++; if (rlow - r0 !== 33) begin errors++; $display("FAIL const_ready_low: got %0d cycles expected 33", rlow - r0); end
        checks++; if (done_idx.size() - d0 !== 1) begin errors++; $display("FAIL const_done_count: got %0d expected 1", done_idx.size() - d0); end
        else begin
            checks++; if (done_idx[d0] !== base + N - 1) begin errors++; $display("FAIL const_done_pos: got %0d expected %0d", done_idx[d0] - base, N - 1); end
        end
    endtask

    task automatic test_vstep();
        int base, bad;
        base = outs.size();
        drive(P_VSTEP, P_VSTEP, N, 0);
        wait_done(done_idx.size() + 1);
        bad = count_bad(P_VSTEP, base);
        checks++; if (outs.size() - base !== N) begin errors++; $display("FAIL vstep_count: got %0d expected %0d", outs.size() - base, N); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL vstep_data: %0d wrong outputs expected 0", bad); end
    endtask

    task automatic test_ramp();
        int base, bad;
        base = outs.size();
        drive(P_RAMP, P_RAMP, N, 0);
        wait_done(done_idx.size() + 1);
        bad = count_bad(P_RAMP, base);
        checks++; if (outs.size() - base !== N) begin errors++; $display("FAIL ramp_count: got %0d expected %0d", outs.size() - base, N); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ramp_data: %0d wrong outputs expected 0", bad); end
        checks++; if (outs.size() > base + 33 && outs[base + 33] !== 8'h08) begin errors++; $display("FAIL ramp_first_interior: got %h expected 08", outs[base + 33]); end
    endtask

    task automatic test_impulse();
        int base, bad;
        base = outs.size();
        drive(P_IMP, P_IMP, N, 0);
        wait_done(done_idx.size() + 1);
        bad = count_bad(P_IMP, base);
        checks++; if (outs.size() - base !== N) begin errors++; $display("FAIL imp_count: got %0d expected %0d", outs.size() - base, N); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL imp_data: %0d wrong outputs expected 0", bad); end
    endtask

    task automatic test_gaps();
        int base, d0, bad, unmatched, tail;
        base = outs.size(); d0 = done_idx.size();
        drive(P_VSTEP, P_VSTEP, N, 40);
        wait_done(d0 + 1);
        bad = count_bad(P_VSTEP, base);
        unmatched = 0; tail = 0;
        for (int j = base; j < outs.size(); j++) begin
            if (oedge[j] > last_acc_edge) tail++;
            else if (!acc_mark.exists(oedge[j])) unmatched++;
        end
        checks++; if (outs.size() - base !== N) begin errors++; $display("FAIL gaps_count: got %0d expected %0d", outs.size() - base, N); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL gaps_data: %0d wrong outputs expected 0", bad); end
        checks++; if (unmatched !== 0) begin errors++; $display("FAIL gaps_unprompted: %0d outputs without accept expected 0", unmatched); end
        checks++; if (tail !== W + 1) begin errors++; $display("FAIL gaps_flush_len: got %0d expected %0d", tail, W + 1); end
        checks++; if (done_idx.size() - d0 !== 1) begin errors++; $display("FAIL gaps_done_count: got %0d expected 1", done_idx.size() - d0); end
    endtask

    task automatic test_reset_mid();
        int base, d0, bad;
        drive(P_VSTEP, P_VSTEP, 500, 0);
        @(negedge clk_i);
        reset = 1'b1;
        @(negedge clk_i);
        checks++; if (sobel_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", sobel_valid_o); end
        checks++; if (gray_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", gray_ready_o); end
        reset = 1'b0;
        base = outs.size(); d0 = done_idx.size();
        drive(P_IMP, P_IMP, N, 0);
        wait_done(d0 + 1);
        bad = count_bad(P_IMP, base);
        checks++; if (outs.size() - base !== N) begin errors++; $display("FAIL rmid_count: got %0d expected %0d", outs.size() - base, N); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_data: %0d wrong outputs expected 0", bad); end
        checks++; if (done_idx.size() - d0 !== 1) begin errors++; $display("FAIL rmid_done_count: got %0d expected 1", done_idx.size() - d0); end
    endtask

    task automatic test_back_to_back();
        int base, d0, bad1, bad2;
        base = outs.size(); d0 = done_idx.size();
        drive(P_RAMP, P_VSTEP, 2 * N, 0);
        wait_done(d0 + 2);
        bad1 = count_bad(P_RAMP, base);
        bad2 = count_bad(P_VSTEP, base + N);
        checks++; if (outs.size() - base !== 2 * N) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", outs.size() - base, 2 * N); end
        checks++; if (bad1 !== 0) begin errors++; $display("FAIL b2b_frame1: %0d wrong outputs expected 0", bad1); end
        checks++; if (bad2 !== 0) begin errors++; $display("FAIL b2b_frame2: %0d wrong outputs expected 0", bad2); end
        checks++; if (done_idx.size() - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_idx.size() - d0); end
        else begin
            checks++; if (done_idx[d0] !== base + N - 1) begin errors++; $display("FAIL b2b_done1_pos: got %0d expected %0d", done_idx[d0] - base, N - 1); end
            checks++; if (done_idx[d0 + 1] !== base + 2 * N - 1) begin errors++; $display("FAIL b2b_done2_pos: got %0d expected %0d", done_idx[d0 + 1] - base, 2 * N - 1); end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_vstep();
        test_ramp();
        test_impulse();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
